// File: rtl/m0_word_serializer_if.sv
// Handshake and serial-pin bundle for m0_word_serializer.
// master drives the parallel word; slave is the serializer.
interface m0_word_serializer_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_frame;
    logic             busy;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_frame,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_frame,
        output busy,
        output done
    );
endinterface

// File: rtl/m0_word_serializer.sv
// Parallel-word to single-pin serializer with frame strobe and inter-frame gap.
// Define M0_SER_PARITY_EN to append an even-parity bit to every frame.
module m0_word_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned GAP       = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    m0_word_serializer_if.slave  bus
);
    localparam int unsigned       CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);
    localparam logic [3:0]        GapLast = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

`ifdef M0_SER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CntW-1:0]  cnt_q;
    logic [3:0]       gap_cnt_q;
    logic             ser_out_q;
    logic             ser_frame_q;
    logic             done_q;
`ifdef M0_SER_PARITY_EN
    logic             parity_q;
`endif

    logic accept;
    logic first_bit;
    logic next_bit;

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.busy      = (state_q != StIdle);
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_frame = ser_frame_q;
    assign bus.done      = done_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign first_bit = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
    // Bit that becomes current after the next shift.
    assign next_bit  = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            cnt_q       <= '0;
            gap_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_frame_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef M0_SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        sreg_q      <= bus.in_data;
                        cnt_q       <= '0;
                        ser_out_q   <= first_bit;
                        ser_frame_q <= 1'b1;
`ifdef M0_SER_PARITY_EN
                        parity_q    <= ^bus.in_data;
`endif
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_q == CntLast) begin
`ifdef M0_SER_PARITY_EN
                        ser_out_q   <= parity_q;
                        state_q     <= StParity;
`else
                        ser_out_q   <= 1'b0;
                        ser_frame_q <= 1'b0;
                        done_q      <= 1'b1;
                        gap_cnt_q   <= '0;
                        state_q     <= (GAP == 0) ? StIdle : StGap;
`endif
                    end else begin
                        cnt_q     <= cnt_q + CntW'(1);
                        ser_out_q <= next_bit;
                        sreg_q    <= MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                    end
                end
`ifdef M0_SER_PARITY_EN
                StParity: begin
                    ser_out_q   <= 1'b0;
                    ser_frame_q <= 1'b0;
                    done_q      <= 1'b1;
                    gap_cnt_q   <= '0;
                    state_q     <= (GAP == 0) ? StIdle : StGap;
                end
`endif
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
